// File: rtl/unipi_se_pwm_capture.sv
// unipi_se_pwm_capture: Avalon-MM PWM period/high-time capture; define UNIPI_SE_PWM_CAPTURE_IRQ_EN to build CONTROL.IE and irq
module unipi_se_pwm_capture #(
  parameter bit RESET_CAPTURE_ENABLE = 1'b0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        pwm_in,
  output logic        irq
);
  typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;
  state_t state, state_nx;
  logic en, ie, valid, ovf, s1, s, s_prev, rise, start, cap, ovf_hit, wr_ctl, wr_sts, unused;
  logic [31:0] period_cnt, high_cnt, period, high;
  assign rise = s & ~s_prev;
  assign wr_ctl = write && address == 2'd0;
  assign wr_sts = write && address == 2'd3;
  assign unused = ^{read, writedata[31:2]};
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = !en ? IDLE :
               state == IDLE ? ARM :
               state == ARM ? (rise ? MEASURE : ARM) :
               ovf_hit ? ARM : MEASURE;
  always_comb begin
    start = en && state == ARM && rise;
    ovf_hit = en && state == MEASURE && period_cnt == '1;
    cap = en && state == MEASURE && rise && !ovf_hit;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      s1 <= 1'b0;
      s <= 1'b0;
      s_prev <= 1'b0;
      period_cnt <= '0;
      high_cnt <= '0;
      period <= '0;
      high <= '0;
      valid <= 1'b0;
      ovf <= 1'b0;
      en <= RESET_CAPTURE_ENABLE;
      readdata <= '0;
    end else begin
      s1 <= pwm_in;
      s <= s1;
      s_prev <= s;
      period_cnt <= state_nx != MEASURE ? '0 : (start || cap) ? 32'd1 : period_cnt + 32'd1;
      high_cnt <= state_nx != MEASURE ? '0 : (start || cap) ? 32'd1 : high_cnt + 32'(s);
      period <= cap ? period_cnt : period;
      high <= cap ? high_cnt : high;
      valid <= cap | (valid & ~(wr_sts & writedata[0]));
      ovf <= ovf_hit | (ovf & ~(wr_sts & writedata[1]));
      en <= wr_ctl ? writedata[0] : en;
      readdata <= address == 2'd0 ? {30'b0, ie, en} :
                  address == 2'd1 ? period :
                  address == 2'd2 ? high : {30'b0, ovf, valid};
    end
`ifdef UNIPI_SE_PWM_CAPTURE_IRQ_EN
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      ie <= 1'b0;
      irq <= 1'b0;
    end else begin
      ie <= wr_ctl ? writedata[1] : ie;
      irq <= ie & (valid | ovf);
    end
`else
  assign ie = 1'b0;
  assign irq = 1'b0;
`endif
endmodule

// File: tb/tb_unipi_se_pwm_capture.sv
// tb_unipi_se_pwm_capture: scoreboard bench with a rise-timestamp reference model
module tb_unipi_se_pwm_capture;
  logic clk = 1'b0, reset_n = 1'b0, read = 1'b0, write = 1'b0, pwm_in = 1'b0, irq;
  logic [1:0] address = 2'd0;
  logic [31:0] writedata = '0, readdata;
  always #5 clk = ~clk;
  unipi_se_pwm_capture dut (
    .clk(clk), .reset_n(reset_n), .address(address), .read(read), .write(write),
    .writedata(writedata), .readdata(readdata), .pwm_in(pwm_in), .irq(irq)
  );
  typedef struct {string name; logic [31:0] data; logic irq;} exp_t;
  exp_t sb[$];
  int checks = 0, errors = 0, cyc = 0;
  logic rv = 1'b0;
  logic m_en, m_ie, m_valid, m_ovf, have_prev;
  logic [31:0] m_period, m_high;
  int prev_rise, prev_high;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    rv <= read;
  end
  always @(negedge clk)
    if (rv) begin
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_read readdata=%h with empty scoreboard", readdata);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checks++;
        if (readdata !== e.data || irq !== e.irq) begin
          errors++;
          $display("FAIL %s readdata=%h irq=%b expected readdata=%h irq=%b", e.name, readdata, irq, e.data, e.irq);
        end
      end
    end
  task automatic m_reset();
    m_en = 1'b0; m_ie = 1'b0; m_valid = 1'b0; m_ovf = 1'b0; have_prev = 1'b0;
    m_period = '0; m_high = '0; prev_rise = 0; prev_high = 0;
  endtask
  task automatic m_rise(input int h);
    if (m_en) begin
      if (have_prev) begin
        m_period = 32'(cyc - prev_rise);
        m_high = 32'(prev_high);
        m_valid = 1'b1;
      end
      prev_rise = cyc;
      prev_high = h;
      have_prev = 1'b1;
    end
  endtask
  function automatic logic [31:0] exp_reg(input logic [1:0] a);
    return a == 2'd0 ? {30'b0, m_ie, m_en} : a == 2'd1 ? m_period : a == 2'd2 ? m_high : {30'b0, m_ovf, m_valid};
  endfunction
  function automatic logic exp_irq();
`ifdef UNIPI_SE_PWM_CAPTURE_IRQ_EN
    return m_ie & (m_valid | m_ovf);
`else
    return 1'b0;
`endif
  endfunction
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic rd(input string nm, input logic [1:0] a);
    @(negedge clk);
    address = a; read = 1'b1;
    sb.push_back('{nm, exp_reg(a), exp_irq()});
    @(negedge clk);
    read = 1'b0;
  endtask
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; write = 1'b1;
    if (a == 2'd0) begin
      if (!d[0]) have_prev = 1'b0;
      m_en = d[0];
`ifdef UNIPI_SE_PWM_CAPTURE_IRQ_EN
      m_ie = d[1];
`endif
    end else if (a == 2'd3) begin
      m_valid &= ~d[0];
      m_ovf &= ~d[1];
    end
    @(negedge clk);
    write = 1'b0;
  endtask
  task automatic run(input int p, input int h, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      pwm_in = 1'b1;
      m_rise(h);
      repeat (h - 1) @(negedge clk);
      @(negedge clk);
      pwm_in = 1'b0;
      repeat (p - h - 1) @(negedge clk);
    end
  endtask
  task automatic rd_all(input string nm);
    rd({nm, "_ctrl"}, 2'd0);
    rd({nm, "_period"}, 2'd1);
    rd({nm, "_high"}, 2'd2);
    rd({nm, "_status"}, 2'd3);
  endtask
  initial begin
    int p, h, n;
    m_reset();
    idle(3);
    reset_n = 1'b1;
    rd_all("reset");
    wr(2'd0, 32'h3);
    idle(4);
    rd("ctrl_ie", 2'd0);
    run(100, 25, 3);
    idle(5);
    rd("cap100_period", 2'd1);
    rd("cap100_high", 2'd2);
    rd("cap100_status", 2'd3);
    wr(2'd1, 32'hDEAD_BEEF);
    wr(2'd2, 32'h1234_5678);
    rd("ro_period", 2'd1);
    rd("ro_high", 2'd2);
    wr(2'd3, 32'h1);
    rd("w1c_valid", 2'd3);
    run(40, 10, 1);
    idle(3);
    rd("recapture", 2'd3);
    rd("recapture_period", 2'd1);
    wr(2'd3, 32'h1);
    @(negedge clk);
    pwm_in = 1'b1;
    m_rise(10);
    idle(2);
    address = 2'd3; writedata = 32'h1; write = 1'b1;
    @(negedge clk);
    write = 1'b0;
    idle(7);
    pwm_in = 1'b0;
    idle(20);
    rd("race_status", 2'd3);
    rd("race_period", 2'd1);
    rd("race_high", 2'd2);
    wr(2'd3, 32'h3);
    @(negedge clk);
    force dut.period_cnt = 32'hFFFF_FFF0;
    #1 release dut.period_cnt;
    m_ovf = 1'b1;
    have_prev = 1'b0;
    idle(30);
    rd_all("ovf");
    run(20, 5, 1);
    idle(3);
    rd("ovf_one_rise", 2'd3);
    run(20, 5, 2);
    idle(3);
    rd_all("ovf_recover");
    @(negedge clk);
    pwm_in = 1'b1;
    idle(5);
    reset_n = 1'b0;
    pwm_in = 1'b0;
    m_reset();
    idle(2);
    reset_n = 1'b1;
    rd_all("midreset");
    wr(2'd0, 32'h1);
    idle(4);
    run(30, 7, 1);
    idle(3);
    rd("midreset_one_rise", 2'd3);
    run(30, 7, 1);
    idle(3);
    rd_all("midreset_two_rise");
    for (int it = 0; it < 10; it++) begin
      p = $urandom_range(60, 6);
      h = $urandom_range(p - 1, 1);
      n = $urandom_range(3, 1);
      if ($urandom_range(3, 0) == 0) begin
        wr(2'd0, 32'h0);
        idle(3);
      end
      wr(2'd0, {30'b0, 1'($urandom_range(1, 0)), 1'b1});
      idle(4);
      run(p, h, n);
      idle($urandom_range(12, 2));
      rd_all("rnd");
      wr(2'd3, 32'($urandom_range(3, 0)));
    end
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
